operate_sequencer: RTL and testbench

//  Multi-cycle controller that executes PDP-8 operate (opcode 7) instructions around the

---
 rtl/operate_sequencer.sv | 155 +++++++++++++++
 tb/tb_operate_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/operate_sequencer.sv
// operate_sequencer: runs one PDP-8 operate (opcode 7) instruction around the external
// micro-instruction decoder and commits AC/L/PC/MQ back to the datapath with start/done.
module operate_sequencer #(
   parameter bit HALT_ON_ILLEGAL = 1'b0,
   parameter bit OSR_ENABLE      = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [11:0] instr,
   input  logic [11:0] ac_in,
   input  logic        l_in,
   input  logic [11:0] pc_in,
   input  logic [11:0] switch_reg,
   input  logic        clear_halt,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        halt,
   output logic [11:0] ac_out,
   output logic        l_out,
   output logic [11:0] pc_out,
   output logic [11:0] mq_out,
   output logic [8:0]  dec_i_reg,
   output logic [11:0] dec_ac,
   output logic        dec_l,
   input  logic [11:0] dec_ac_micro,
   input  logic        dec_l_micro,
   input  logic        dec_skip,
   input  logic        dec_g1,
   input  logic        dec_g2,
   input  logic        dec_g3
);
   // state     | meaning
   // S_IDLE    | waiting for start; outputs hold the last commit
   // S_ISSUE   | instruction and operands presented to the decoder
   // S_CAPTURE | decoder results registered, legality checked
   // S_COMMIT  | effects applied to AC/L/PC/MQ/halt, done pulses next cycle
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_COMMIT} state_t;

   state_t      r_state, w_next;
   logic [2:0]  r_opc;
   logic        r_cla, r_mqa, r_mql, r_osr, r_hlt;
   logic [11:0] r_ac, r_pc, r_sw, r_ac_micro, r_mq, r_ac_out, r_pc_out, r_dec_ac;
   logic        r_l, r_l_micro, r_skip, r_g1, r_g2, r_bad;
   logic        r_done, r_illegal, r_halt, r_l_out, r_dec_l;
   logic [8:0]  r_dec_i;
   logic        w_accept, w_onehot, w_l_c, w_halt_set;
   logic [11:0] w_a, w_ac_c, w_mq_c, w_pc_c;

   // The done cycle still counts as busy, so a start there is dropped as well.
   assign w_accept = (r_state == S_IDLE) && !r_done && start;
   assign w_onehot = (dec_g1 ^ dec_g2 ^ dec_g3) & ~(dec_g1 & dec_g2 & dec_g3);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = S_ISSUE;
         S_ISSUE:   w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_COMMIT;
         S_COMMIT:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_a        = r_cla ? 12'o0000 : r_ac;
      w_ac_c     = r_ac_out;
      w_l_c      = r_l_out;
      w_mq_c     = r_mq;
      w_pc_c     = r_pc + 12'd1;
      w_halt_set = 1'b0;
      if (r_bad) begin
         w_halt_set = HALT_ON_ILLEGAL;
      end else if (r_g1) begin
         w_ac_c = r_ac_micro;
         w_l_c  = r_l_micro;
      end else if (r_g2) begin
         w_ac_c     = (OSR_ENABLE && r_osr) ? (r_ac_micro | r_sw) : r_ac_micro;
         w_l_c      = r_l;
         w_halt_set = r_hlt;
         if (r_skip) w_pc_c = r_pc + 12'd2;
      end else begin
         w_l_c = r_l;
         // Swap reads the pre-instruction MQ; both sides come from registers.
         case ({r_mqa, r_mql})
            2'b11:   begin w_ac_c = r_mq;     w_mq_c = w_a; end
            2'b10:   w_ac_c = w_a | r_mq;
            2'b01:   begin w_ac_c = 12'o0000; w_mq_c = w_a; end
            default: w_ac_c = w_a;
         endcase
      end
      w_halt_set = w_halt_set && (r_state == S_COMMIT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_opc <= 3'd0;  r_cla <= 1'b0; r_mqa <= 1'b0; r_mql <= 1'b0;
         r_osr <= 1'b0;  r_hlt <= 1'b0;
         r_ac  <= 12'd0; r_l <= 1'b0; r_pc <= 12'd0; r_sw <= 12'd0;
         r_ac_micro <= 12'd0; r_l_micro <= 1'b0; r_skip <= 1'b0;
         r_g1  <= 1'b0;  r_g2 <= 1'b0; r_bad <= 1'b0;
         r_dec_i <= 9'd0; r_dec_ac <= 12'd0; r_dec_l <= 1'b0;
         r_done <= 1'b0; r_illegal <= 1'b0; r_halt <= 1'b0;
         r_ac_out <= 12'd0; r_l_out <= 1'b0; r_pc_out <= 12'd0; r_mq <= 12'd0;
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         if (w_accept) begin
            r_opc <= instr[11:9]; r_cla <= instr[7]; r_mqa <= instr[6];
            r_mql <= instr[4];    r_osr <= instr[2]; r_hlt <= instr[1];
            r_ac  <= ac_in; r_l <= l_in; r_pc <= pc_in; r_sw <= switch_reg;
            r_dec_i  <= instr[8:0];
            r_dec_ac <= ac_in;
            r_dec_l  <= l_in;
         end
         if (r_state == S_CAPTURE) begin
            r_ac_micro <= dec_ac_micro;
            r_l_micro  <= dec_l_micro;
            r_skip     <= dec_skip;
            r_g1       <= dec_g1;
            r_g2       <= dec_g2;
            r_bad      <= (r_opc != 3'b111) || !w_onehot;
         end
         if (r_state == S_COMMIT) begin
            r_done    <= 1'b1;
            r_illegal <= r_bad;
            r_ac_out  <= w_ac_c;
            r_l_out   <= w_l_c;
            r_pc_out  <= w_pc_c;
            r_mq      <= w_mq_c;
         end
         if (w_halt_set)      r_halt <= 1'b1;
         else if (clear_halt) r_halt <= 1'b0;
      end
   end

   assign busy      = (r_state != S_IDLE) || r_done;
   assign done      = r_done;
   assign illegal   = r_illegal;
   assign halt      = r_halt;
   assign ac_out    = r_ac_out;
   assign l_out     = r_l_out;
   assign pc_out    = r_pc_out;
   assign mq_out    = r_mq;
   assign dec_i_reg = r_dec_i;
   assign dec_ac    = r_dec_ac;
   assign dec_l     = r_dec_l;

endmodule

// File: tb/tb_operate_sequencer.sv
// tb_operate_sequencer: directed operate-instruction vectors with hand-computed results;
// the decoder outputs are driven as constants matching each instruction.
module tb_operate_sequencer;
   logic        clk, reset_n, start, clear_halt, l_in;
   logic [11:0] instr, ac_in, pc_in, switch_reg, dec_ac_micro;
   logic        dec_l_micro, dec_skip, dec_g1, dec_g2, dec_g3;
   logic        busy, done, illegal, halt, l_out, dec_l;
   logic [11:0] ac_out, pc_out, mq_out, dec_ac;
   logic [8:0]  dec_i_reg;

   int          total, bad, lat, n_done;
   logic [8:0]  seen_i;
   logic [11:0] seen_ac;
   logic        seen_busy, seen_busy_done, seen_ill;

   operate_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .ac_in(ac_in),
      .l_in(l_in), .pc_in(pc_in), .switch_reg(switch_reg), .clear_halt(clear_halt),
      .busy(busy), .done(done), .illegal(illegal), .halt(halt), .ac_out(ac_out),
      .l_out(l_out), .pc_out(pc_out), .mq_out(mq_out), .dec_i_reg(dec_i_reg),
      .dec_ac(dec_ac), .dec_l(dec_l), .dec_ac_micro(dec_ac_micro),
      .dec_l_micro(dec_l_micro), .dec_skip(dec_skip), .dec_g1(dec_g1),
      .dec_g2(dec_g2), .dec_g3(dec_g3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_op(input logic [11:0] i_w, a_w, input logic l_w,
                         input logic [11:0] pc_w, sw_w, am_w,
                         input logic lm_w, sk_w, g1_w, g2_w, g3_w);
      int k;
      repeat (2) @(negedge clk);
      instr = i_w; ac_in = a_w; l_in = l_w; pc_in = pc_w; switch_reg = sw_w;
      dec_ac_micro = am_w; dec_l_micro = lm_w; dec_skip = sk_w;
      dec_g1 = g1_w; dec_g2 = g2_w; dec_g3 = g3_w;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen_i = dec_i_reg; seen_ac = dec_ac; seen_busy = busy;
      lat = 99; seen_ill = 1'b0; seen_busy_done = 1'b0;
      k = 0;
      while (lat == 99 && k < 8) begin
         @(posedge clk); #1;
         k++;
         if (done) begin lat = k; seen_ill = illegal; seen_busy_done = busy; end
      end
   endtask

   task automatic test_reset;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
      total++; if (illegal !== 1'b0 || halt !== 1'b0) begin bad++; $display("FAIL reset_illegal_halt: got %b%b want 00", illegal, halt); end
      total++; if (ac_out !== 12'o0 || l_out !== 1'b0) begin bad++; $display("FAIL reset_ac_l: got %o %b want 0 0", ac_out, l_out); end
      total++; if (pc_out !== 12'o0 || mq_out !== 12'o0) begin bad++; $display("FAIL reset_pc_mq: got %o %o want 0 0", pc_out, mq_out); end
      total++; if (dec_i_reg !== 9'o0 || dec_ac !== 12'o0 || dec_l !== 1'b0) begin bad++; $display("FAIL reset_dec: got %o %o %b want 0 0 0", dec_i_reg, dec_ac, dec_l); end
   endtask

   task automatic test_cla;
      run_op(12'o7200, 12'o1234, 1'b1, 12'o0200, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (lat !== 3) begin bad++; $display("FAIL cla_latency: got %0d want 3", lat); end
      total++; if (seen_busy !== 1'b1 || seen_busy_done !== 1'b1) begin bad++; $display("FAIL cla_busy: got %b %b want 1 1", seen_busy, seen_busy_done); end
      total++; if (seen_i !== 9'o200 || seen_ac !== 12'o1234) begin bad++; $display("FAIL cla_issue: got %o %o want 200 1234", seen_i, seen_ac); end
      total++; if (ac_out !== 12'o0000 || l_out !== 1'b1) begin bad++; $display("FAIL cla_result: got %o %b want 0000 1", ac_out, l_out); end
      total++; if (pc_out !== 12'o0201 || seen_ill !== 1'b0) begin bad++; $display("FAIL cla_pc: got %o ill=%b want 0201 0", pc_out, seen_ill); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL cla_pulse: got done=%b busy=%b want 0 0", done, busy); end
      total++; if (ac_out !== 12'o0000 || pc_out !== 12'o0201) begin bad++; $display("FAIL cla_hold: got %o %o want 0000 0201", ac_out, pc_out); end
   endtask

   task automatic test_skip;
      run_op(12'o7450, 12'o0005, 1'b0, 12'o0100, 12'o0, 12'o0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      total++; if (pc_out !== 12'o0102 || ac_out !== 12'o0005) begin bad++; $display("FAIL sna_skip: got %o %o want 0102 0005", pc_out, ac_out); end
      run_op(12'o7450, 12'o0000, 1'b1, 12'o0100, 12'o0, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (pc_out !== 12'o0101 || l_out !== 1'b1) begin bad++; $display("FAIL sna_noskip: got %o l=%b want 0101 1", pc_out, l_out); end
      run_op(12'o7450, 12'o0005, 1'b0, 12'o7777, 12'o0, 12'o0005, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      total++; if (pc_out !== 12'o0001 || l_out !== 1'b0) begin bad++; $display("FAIL sna_wrap: got %o l=%b want 0001 0", pc_out, l_out); end
      run_op(12'o7200, 12'o0000, 1'b0, 12'o7777, 12'o0, 12'o0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (pc_out !== 12'o0000) begin bad++; $display("FAIL pc_wrap1: got %o want 0000", pc_out); end
   endtask

   task automatic test_osr_hlt;
      run_op(12'o7604, 12'o1234, 1'b0, 12'o0400, 12'o4321, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (ac_out !== 12'o4321 || halt !== 1'b0) begin bad++; $display("FAIL osr: got %o halt=%b want 4321 0", ac_out, halt); end
      run_op(12'o7402, 12'o0017, 1'b0, 12'o0410, 12'o0, 12'o0017, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (halt !== 1'b1 || ac_out !== 12'o0017) begin bad++; $display("FAIL hlt_set: got halt=%b ac=%o want 1 0017", halt, ac_out); end
      repeat (3) @(posedge clk); #1;
      total++; if (halt !== 1'b1) begin bad++; $display("FAIL hlt_sticky: got %b want 1", halt); end
      @(negedge clk); clear_halt = 1'b1;
      @(negedge clk); clear_halt = 1'b0;
      #1;
      total++; if (halt !== 1'b0) begin bad++; $display("FAIL hlt_clear: got %b want 0", halt); end
      clear_halt = 1'b1;
      run_op(12'o7402, 12'o0017, 1'b0, 12'o0420, 12'o0, 12'o0017, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (halt !== 1'b1) begin bad++; $display("FAIL hlt_set_wins: got %b want 1", halt); end
      @(posedge clk); #1;
      clear_halt = 1'b0;
      total++; if (halt !== 1'b0) begin bad++; $display("FAIL hlt_clear_after: got %b want 0", halt); end
   endtask

   task automatic test_mq;
      run_op(12'o7421, 12'o1111, 1'b0, 12'o0500, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (mq_out !== 12'o1111 || ac_out !== 12'o0000) begin bad++; $display("FAIL mql: got mq=%o ac=%o want 1111 0000", mq_out, ac_out); end
      total++; if (l_out !== 1'b0) begin bad++; $display("FAIL mql_link: got %b want 0", l_out); end
      run_op(12'o7521, 12'o2222, 1'b0, 12'o0501, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (ac_out !== 12'o1111 || mq_out !== 12'o2222) begin bad++; $display("FAIL swp: got ac=%o mq=%o want 1111 2222", ac_out, mq_out); end
      total++; if (pc_out !== 12'o0502) begin bad++; $display("FAIL swp_pc: got %o want 0502", pc_out); end
   endtask

   task automatic test_illegal;
      int k;
      repeat (2) @(negedge clk);
      instr = 12'o1234; ac_in = 12'o1111; l_in = 1'b0; pc_in = 12'o0300;
      dec_ac_micro = 12'o7070; dec_l_micro = 1'b1; dec_skip = 1'b0;
      dec_g1 = 1'b1; dec_g2 = 1'b0; dec_g3 = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      n_done = 0; lat = 99; seen_ill = 1'b0;
      for (k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 2) start = 1'b0;
         if (done) begin
            n_done++;
            if (lat == 99) begin lat = k; seen_ill = illegal; end
         end
      end
      total++; if (n_done !== 1 || lat !== 3) begin bad++; $display("FAIL illegal_done: got count=%0d lat=%0d want 1 3", n_done, lat); end
      total++; if (seen_ill !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse: got %b then %b want 1 then 0", seen_ill, illegal); end
      total++; if (ac_out !== 12'o1111 || l_out !== 1'b0 || mq_out !== 12'o2222) begin bad++; $display("FAIL illegal_hold: got %o %b %o want 1111 0 2222", ac_out, l_out, mq_out); end
      total++; if (pc_out !== 12'o0301 || halt !== 1'b0) begin bad++; $display("FAIL illegal_pc: got %o halt=%b want 0301 0", pc_out, halt); end
      run_op(12'o7200, 12'o1111, 1'b0, 12'o0310, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      total++; if (seen_ill !== 1'b1 || ac_out !== 12'o1111 || pc_out !== 12'o0311) begin bad++; $display("FAIL illegal_groups: got ill=%b ac=%o pc=%o want 1 1111 0311", seen_ill, ac_out, pc_out); end
   endtask

   task automatic test_reset_mid;
      repeat (2) @(negedge clk);
      instr = 12'o7200; ac_in = 12'o1234; l_in = 1'b0; pc_in = 12'o0600;
      dec_ac_micro = 12'o0000; dec_l_micro = 1'b0; dec_skip = 1'b0;
      dec_g1 = 1'b1; dec_g2 = 1'b0; dec_g3 = 1'b0;
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      total++; if (ac_out !== 12'o0 || pc_out !== 12'o0 || mq_out !== 12'o0) begin bad++; $display("FAIL midreset_out: got %o %o %o want 0 0 0", ac_out, pc_out, mq_out); end
      total++; if (busy !== 1'b0 || dec_i_reg !== 9'o0 || dec_ac !== 12'o0) begin bad++; $display("FAIL midreset_ctl: got busy=%b %o %o want 0 0 0", busy, dec_i_reg, dec_ac); end
      n_done = 0;
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (done) n_done++; end
      @(negedge clk); reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (done) n_done++; end
      total++; if (n_done !== 0) begin bad++; $display("FAIL midreset_nodone: got %0d want 0", n_done); end
      run_op(12'o7200, 12'o1234, 1'b1, 12'o0700, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (lat !== 3 || ac_out !== 12'o0000 || l_out !== 1'b1 || pc_out !== 12'o0701) begin bad++; $display("FAIL midreset_after: got lat=%0d %o %b %o want 3 0000 1 0701", lat, ac_out, l_out, pc_out); end
   endtask

   initial begin
      total = 0; bad = 0;
      reset_n = 1'b0; start = 1'b0; clear_halt = 1'b0;
      instr = 12'o0; ac_in = 12'o0; l_in = 1'b0; pc_in = 12'o0; switch_reg = 12'o0;
      dec_ac_micro = 12'o0; dec_l_micro = 1'b0; dec_skip = 1'b0;
      dec_g1 = 1'b0; dec_g2 = 1'b0; dec_g3 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk); reset_n = 1'b1;
      test_cla;
      test_skip;
      test_osr_hlt;
      test_mq;
      test_illegal;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
